// File: rtl/string_hw_avalon_if.sv
// Avalon-MM register front end for the string accelerator.
// Holds operand strings, launches the engine and shadows its result.
module string_hw_avalon_if #(
  parameter int MAX_BLOCKS     = 8,
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic [3:0]              avs_byteenable,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic                    irq,
  output logic                    acc_go,
  output logic [3:0]              acc_index,
  output logic [7:0]              acc_length,
  output logic [MAX_BLOCKS*32-1:0] acc_A,
  output logic [MAX_BLOCKS*32-1:0] acc_B,
  input  logic                    acc_done,
  input  logic [MAX_BLOCKS*32-1:0] acc_result
);

  localparam int MB = MAX_BLOCKS;
  localparam int NC = 4 * MB;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_REL    = 2'd3;

  localparam logic [ADDR_W-1:0] AD_CTRL = ADDR_W'(3 * MB);
  localparam logic [ADDR_W-1:0] AD_STAT = ADDR_W'(3 * MB + 1);

  logic [31:0]   a_q [MB];
  logic [31:0]   a_d [MB];
  logic [31:0]   b_q [MB];
  logic [31:0]   b_d [MB];
  logic [31:0]   r_q [MB];
  logic [31:0]   r_d [MB];
  logic [31:0]   res_w [MB];
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    len_q, len_d;
  logic          irqen_q, irqen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          go_q, go_d;
  logic [31:0]   rd_q, rd_d;
  logic [31:0]   be_mask;
  logic          wr_ctrl, wr_stat;
  logic          start_w, set_err, set_done;
  logic          unused_wd;

  assign unused_wd = ^{avs_writedata[30:17], avs_writedata[15:12]};

  assign be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                    {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
  assign wr_ctrl = avs_write && (avs_address == AD_CTRL);
  assign wr_stat = avs_write && (avs_address == AD_STAT);

  // Char c lives in word c/4, lane c%4; the engine wants char 0 in the MSBs
  for (genvar k = 0; k < MB; k++) begin : g_w
    for (genvar j = 0; j < 4; j++) begin : g_b
      localparam int P = (NC - 1 - 4 * k - j) * 8;
      assign acc_A[P +: 8]        = a_q[k][8*j +: 8];
      assign acc_B[P +: 8]        = b_q[k][8*j +: 8];
      assign res_w[k][8*j +: 8]   = acc_result[P +: 8];
    end
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    idx_d    = idx_q;
    len_d    = len_q;
    irqen_d  = irqen_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    st_d     = st_q;
    cnt_d    = cnt_q;
    start_w  = 1'b0;
    set_err  = 1'b0;
    set_done = 1'b0;

    if (wr_stat && avs_byteenable[0]) begin
      if (avs_writedata[1]) done_d = 1'b0;
      if (avs_writedata[2]) err_d  = 1'b0;
    end

    for (int k = 0; k < MB; k++) begin
      if (avs_write && avs_address == ADDR_W'(k)) begin
        if (busy_q) set_err = 1'b1;
        else a_d[k] = (a_q[k] & ~be_mask) | (avs_writedata & be_mask);
      end
      if (avs_write && avs_address == ADDR_W'(MB + k)) begin
        if (busy_q) set_err = 1'b1;
        else b_d[k] = (b_q[k] & ~be_mask) | (avs_writedata & be_mask);
      end
    end

    if (wr_ctrl) begin
      if (busy_q) begin
        set_err = 1'b1;
      end else begin
        if (avs_byteenable[0]) begin
          idx_d      = avs_writedata[3:0];
          len_d[3:0] = avs_writedata[7:4];
        end
        if (avs_byteenable[1]) len_d[7:4] = avs_writedata[11:8];
        if (avs_byteenable[2]) irqen_d = avs_writedata[16];
        start_w = avs_byteenable[3] & avs_writedata[31];
      end
    end

    case (st_q)
      S_IDLE: begin
        if (start_w) begin
          if (idx_d > 4'd4) begin
            set_err = 1'b1;
          end else begin
            busy_d = 1'b1;
            st_d   = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d = '0;
        st_d  = S_WAIT;
      end
      S_WAIT: begin
        if (acc_done) begin
          r_d      = res_w;
          set_done = 1'b1;
          st_d     = S_REL;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          set_err = 1'b1;
          st_d    = S_REL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (!acc_done) begin
          busy_d = 1'b0;
          st_d   = S_IDLE;
        end
      end
    endcase

    // Hardware sets override a same-cycle write-1-to-clear
    if (set_err)  err_d  = 1'b1;
    if (set_done) done_d = 1'b1;
  end

  assign go_d = (st_d == S_WAIT);

  always_comb begin
    rd_d = '0;
    if (avs_read) begin
      for (int k = 0; k < MB; k++) begin
        if (avs_address == ADDR_W'(k))          rd_d = a_q[k];
        if (avs_address == ADDR_W'(MB + k))     rd_d = b_q[k];
        if (avs_address == ADDR_W'(2 * MB + k)) rd_d = r_q[k];
      end
      if (avs_address == AD_CTRL)
        rd_d = {15'b0, irqen_q, 4'b0, len_q, idx_q};
      if (avs_address == AD_STAT)
        rd_d = {29'b0, err_q, done_q, busy_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MB; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
      idx_q   <= '0;
      len_q   <= '0;
      irqen_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      irqen_q <= irqen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
      rd_q    <= rd_d;
    end
  end

  assign avs_readdata = rd_q;
  assign acc_go       = go_q;
  assign acc_index    = idx_q;
  assign acc_length   = len_q;
  assign irq          = done_q & irqen_q;

endmodule

// File: tb/tb_string_hw_avalon_if.sv
// Bench for string_hw_avalon_if: behavioural accelerator stub plus
// a character-level register model; randomized and directed traffic.
module tb_string_hw_avalon_if;

  localparam int MB = 8;
  localparam int NC = 4 * MB;
  localparam int AW = 6;
  localparam int TO = 16;
  localparam int A_CTRL = 3 * MB;
  localparam int A_STAT = 3 * MB + 1;

  typedef logic [7:0] str_t [NC];

  logic            clk;
  logic            reset;
  logic [AW-1:0]   avs_address;
  logic            avs_write;
  logic [31:0]     avs_writedata;
  logic [3:0]      avs_byteenable;
  logic            avs_read;
  logic [31:0]     avs_readdata;
  logic            irq;
  logic            acc_go;
  logic [3:0]      acc_index;
  logic [7:0]      acc_length;
  logic [NC*8-1:0] acc_A;
  logic [NC*8-1:0] acc_B;
  logic            acc_done;
  logic [NC*8-1:0] acc_result;

  string_hw_avalon_if #(
    .MAX_BLOCKS(MB), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_read(avs_read), .avs_readdata(avs_readdata),
    .irq(irq), .acc_go(acc_go), .acc_index(acc_index),
    .acc_length(acc_length), .acc_A(acc_A), .acc_B(acc_B),
    .acc_done(acc_done), .acc_result(acc_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour of the string engine, char by char
  function automatic str_t acc_ref(int idx, int len, str_t a, str_t b);
    str_t r;
    bit ok, found;
    for (int i = 0; i < NC; i++) r[i] = 8'h00;
    case (idx)
      0: r = a;
      1: for (int i = 0; i < NC; i++)
           r[i] = (a[i] >= 8'h61 && a[i] <= 8'h7a) ? a[i] - 8'd32 : a[i];
      2: for (int i = 0; i < NC; i++)
           r[i] = (a[i] >= 8'h41 && a[i] <= 8'h5a) ? a[i] + 8'd32 : a[i];
      3: for (int i = 0; i < NC; i++) r[i] = a[NC-1-i];
      4: begin
        r[0] = 8'hFF;
        found = 1'b0;
        for (int p = 0; p + len <= NC; p++) begin
          ok = 1'b1;
          for (int j = 0; j < len; j++) if (b[j] != a[p+j]) ok = 1'b0;
          if (ok && !found) begin
            r[0] = 8'(p);
            found = 1'b1;
          end
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] wordof(str_t s, int k);
    return {s[4*k+3], s[4*k+2], s[4*k+1], s[4*k]};
  endfunction

  // Accelerator stub
  bit hang;
  int lat;

  initial begin
    str_t sa, sb, sr;
    acc_done   = 1'b0;
    acc_result = '0;
    forever begin
      @(negedge clk);
      if (acc_go && !acc_done && !hang) begin
        repeat (lat) @(negedge clk);
        for (int c = 0; c < NC; c++) begin
          sa[c] = acc_A[(NC-1-c)*8 +: 8];
          sb[c] = acc_B[(NC-1-c)*8 +: 8];
        end
        sr = acc_ref(int'(acc_index), int'(acc_length), sa, sb);
        for (int c = 0; c < NC; c++) acc_result[(NC-1-c)*8 +: 8] = sr[c];
        acc_done = 1'b1;
        for (int t = 0; t < 50 && acc_go; t++) @(negedge clk);
        @(negedge clk);
        acc_done = 1'b0;
      end
    end
  end

  int  go_rises = 0;
  int  go_cycles = 0;
  bit  go_prev = 1'b0;

  always @(negedge clk) begin
    if (acc_go) go_cycles++;
    if (acc_go && !go_prev) go_rises++;
    go_prev = acc_go;
  end

  // Register model
  str_t       ma, mb, mr;
  logic [3:0] m_idx;
  logic [7:0] m_len;
  bit         m_irqen, m_busy, m_done, m_err;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      ma[i] = 8'h00;
      mb[i] = 8'h00;
      mr[i] = 8'h00;
    end
    m_idx = '0;
    m_len = '0;
    m_irqen = 0;
    m_busy = 0;
    m_done = 0;
    m_err = 0;
  endtask

  function automatic logic [31:0] exp_status();
    return {29'b0, m_err, m_done, m_busy};
  endfunction

  task automatic av_wr(int addr, logic [31:0] d, logic [3:0] be);
    @(negedge clk);
    avs_address    = AW'(addr);
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    @(negedge clk);
    avs_write      = 1'b0;
    avs_byteenable = 4'h0;
  endtask

  task automatic av_rd(int addr, output logic [31:0] d);
    @(negedge clk);
    avs_address = AW'(addr);
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wr(int addr, logic [31:0] d, logic [3:0] be);
    av_wr(addr, d, be);
    if (addr < 2 * MB) begin
      if (m_busy) m_err = 1;
      else
        for (int j = 0; j < 4; j++)
          if (be[j]) begin
            if (addr < MB) ma[4*addr+j] = d[8*j +: 8];
            else mb[4*(addr-MB)+j] = d[8*j +: 8];
          end
    end else if (addr == A_CTRL) begin
      if (m_busy) m_err = 1;
      else begin
        m_idx = d[3:0];
        m_len = d[11:4];
        m_irqen = d[16];
        if (d[31]) begin
          if (m_idx > 4) m_err = 1;
          else begin
            m_busy = 1;
            if (hang) m_err = 1;
            else begin
              mr = acc_ref(int'(m_idx), int'(m_len), ma, mb);
              m_done = 1;
            end
          end
        end
      end
    end else if (addr == A_STAT) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err = 0;
    end
  endtask

  task automatic wait_idle(string tag, output logic [31:0] s);
    int n;
    n = 0;
    do begin
      av_rd(A_STAT, s);
      n++;
    end while (s[0] && n < 100);
    m_busy = 0;
    check({tag, "_status"}, s, exp_status());
  endtask

  task automatic check_regs(string tag);
    logic [31:0] v;
    for (int k = 0; k < MB; k++) begin
      av_rd(k, v);
      check($sformatf("%s_A%0d", tag, k), v, wordof(ma, k));
      av_rd(MB + k, v);
      check($sformatf("%s_B%0d", tag, k), v, wordof(mb, k));
      av_rd(2 * MB + k, v);
      check($sformatf("%s_R%0d", tag, k), v, wordof(mr, k));
    end
    av_rd(A_CTRL, v);
    check({tag, "_ctrl"}, v, {15'b0, m_irqen, 4'b0, m_len, m_idx});
    for (int k = 0; k < MB; k++) begin
      v = {ma[4*k], ma[4*k+1], ma[4*k+2], ma[4*k+3]};
      check($sformatf("%s_accA%0d", tag, k), acc_A[(MB-1-k)*32 +: 32], v);
      v = {mb[4*k], mb[4*k+1], mb[4*k+2], mb[4*k+3]};
      check($sformatf("%s_accB%0d", tag, k), acc_B[(MB-1-k)*32 +: 32], v);
    end
    check({tag, "_idx"}, 32'(acc_index), 32'(m_idx));
    check({tag, "_len"}, 32'(acc_length), 32'(m_len));
    check({tag, "_irq"}, 32'(irq), 32'(m_done & m_irqen));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, v;
    int r0, c0, idx, len, ir, addr;
    reset = 1'b1;
    avs_address = '0;
    avs_write = 1'b0;
    avs_read = 1'b0;
    avs_writedata = '0;
    avs_byteenable = '0;
    hang = 0;
    lat = 3;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_go", 32'(acc_go), 0);
    check("rst_irq", 32'(irq), 0);
    av_rd(A_STAT, s);
    check("rst_status", s, 0);
    check_regs("rst");

    // Uppercase
    wr(0, 32'h6463_6261, 4'hF);
    wr(A_CTRL, 32'h8000_0001, 4'hF);
    check("up_go_early", 32'(acc_go), 0);
    @(negedge clk);
    check("up_go_lat2", 32'(acc_go), 1);
    wait_idle("up", s);
    check("up_status_const", s, 32'h2);
    av_rd(2 * MB, v);
    check("up_res0_const", v, 32'h4443_4241);
    check("up_go_low", 32'(acc_go), 0);
    check_regs("up");

    // Search
    wr(A_STAT, 32'h2, 4'hF);
    wr(0, 32'h6568_7878, 4'hF);
    wr(1, 32'h006F_6C6C, 4'hF);
    wr(MB, 32'h6C6C_6568, 4'hF);
    wr(MB + 1, 32'h0000_006F, 4'hF);
    wr(A_CTRL, 32'h8000_0054, 4'hF);
    wait_idle("srch", s);
    av_rd(2 * MB, v);
    check("srch_pos_const", v, 32'h2);
    check_regs("srch");
    wr(A_STAT, 32'h2, 4'hF);
    av_rd(A_STAT, s);
    check("srch_w1c", s, 32'h0);

    // Invalid index
    r0 = go_rises;
    wr(A_CTRL, 32'h8000_0007, 4'hF);
    repeat (6) @(negedge clk);
    check("inv_rises", 32'(go_rises - r0), 0);
    wait_idle("inv", s);
    check("inv_status_const", s, 32'h4);
    wr(A_STAT, 32'h4, 4'hF);

    // Busy protection
    lat = 10;
    r0 = go_rises;
    wr(A_CTRL, 32'h8000_0001, 4'hF);
    repeat (3) @(negedge clk);
    wr(0, 32'hFFFF_FFFF, 4'hF);
    wr(A_CTRL, 32'h8000_0001, 4'hF);
    wait_idle("busy", s);
    check("busy_rises", 32'(go_rises - r0), 1);
    check("busy_status_const", s, 32'h6);
    check_regs("busy");
    wr(A_STAT, 32'h6, 4'hF);

    // Timeout
    hang = 1;
    c0 = go_cycles;
    wr(A_CTRL, 32'h8000_0000, 4'hF);
    wait_idle("tmo", s);
    check("tmo_go_cycles", 32'(go_cycles - c0), 32'(TO));
    check("tmo_status_const", s, 32'h4);
    check_regs("tmo");
    hang = 0;
    wr(A_STAT, 32'h4, 4'hF);

    // Interrupt and byte enables
    lat = 2;
    wr(A_CTRL, 32'h8001_0003, 4'hF);
    wait_idle("irq", s);
    check("irq_high", 32'(irq), 1);
    wr(A_STAT, 32'h2, 4'hF);
    check("irq_cleared", 32'(irq), 0);
    wr(1, 32'h0000_AA00, 4'b0010);
    check("be_char5", 32'(acc_A[(NC-1-5)*8 +: 8]), 32'hAA);
    check_regs("be");

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < 4; w++) begin
        addr = $urandom_range(0, 3 * MB - 1);
        wr(addr, $urandom, 4'($urandom_range(0, 15)));
      end
      idx = $urandom_range(0, 6);
      len = $urandom_range(0, 6);
      ir  = $urandom_range(0, 1);
      lat = $urandom_range(1, 8);
      if (idx == 4) wr(MB, wordof(ma, 1), 4'hF);
      wr(A_CTRL, {1'b1, 14'b0, 1'(ir), 4'b0, 8'(len), 4'(idx)}, 4'hF);
      wait_idle($sformatf("rnd%0d", it), s);
      addr = $urandom_range(A_STAT + 1, 63);
      wr(addr, $urandom, 4'hF);
      av_rd(addr, v);
      check($sformatf("rnd%0d_unmapped", it), v, 0);
      check_regs($sformatf("rnd%0d", it));
      wr(A_STAT, {29'b0, 2'($urandom_range(0, 3)), 1'b0}, 4'hF);
      av_rd(A_STAT, s);
      check($sformatf("rnd%0d_w1c", it), s, exp_status());
    end

    // Reset in the middle of a launch
    hang = 1;
    wr(A_CTRL, 32'h8000_0000, 4'hF);
    repeat (4) @(negedge clk);
    check("mid_go_high", 32'(acc_go), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_go_drop", 32'(acc_go), 0);
    reset = 1'b0;
    hang = 0;
    model_reset();
    av_rd(A_STAT, s);
    check("mid_status", s, 0);
    check_regs("mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
